ps2_key_ctrl: RTL and testbench
===============================

# ps2_key_ctrl

Scan-code sequencer that sits directly behind the PS/2 keyboard receiver and drains its 8-entry byte FIFO through the `ready`/`nextdata_n` handshake. It interprets make, break (`F0`) and extended (`E0`) prefixes, and tracks the currently held key and the shift state. It also converts the held key to ASCII and counts distinct key presses. Its outputs feed the seven-segment / display logic of the keyboard experiment.

## Interface
- `CNT_W`, default 8: width of press counter.
- `clk`  in  1  system clock, same domain as the receiver.
- `clrn`  in  1  asynchronous, active-high reset; clears all state.
- `kb_data`  in  8  receiver FIFO head byte; valid while `kb_ready`=1.
- `kb_ready`  in  1  receiver FIFO non-empty.
- `kb_overflow`  in  1  receiver overflow flag.
- `nextdata_n`  out  1  active-low pop to receiver; registered; reset 1.
- `key_code`  out  8  scan code of held (or last held) key; reset 0x00.
- `key_ext`  out  1  held key was `E0`-prefixed; reset 0.
- `key_ascii`  out  8  ASCII of `key_code` under current shift; 0x00 if unmapped or `key_ext`; reset 0x00.
- `key_down`  out  1  a non-shift key is currently held; reset 0.
- `shift`  out  1  either shift key held; reset 0.
- `press_stb`  out  1  one-cycle pulse on each counted press; reset 0.
- `press_cnt`  out  CNT_W  counted presses, wraps; reset 0.
- `err`  out  1  sticky, set on `kb_overflow`=1 or a protocol error; cleared only by `clrn`.

## Operation
- FSM states: IDLE, POP, PROC.
  - IDLE: if `kb_ready`, latch `kb_data` into `byte_q`, go to POP; else stay.
  - POP: `nextdata_n`=0 for exactly this one cycle, go to PROC.
  - PROC: apply the byte rules below, go to IDLE.
- Internal flags `brk` and `ext_q` record a pending `F0` and a pending `E0`.
- Byte rules, applied in PROC:
  - `E0`: set `ext_q`.
  - `F0`: set `brk`.
  - Any other byte with `brk`=1 is a release:
    - code 0x12 or 0x59 (shift codes): `shift`←0.
    - else, if code equals `key_code` and `ext_q` equals `key_ext`: `key_down`←0. `key_code` keeps its value.
    - clear `brk` and `ext_q`.
  - Any other byte with `brk`=0 is a make:
    - shift code with `ext_q`=0: `shift`←1.
    - else, if `key_down`=0, or code≠`key_code`, or `ext_q`≠`key_ext`: new press. Load `key_code` and `key_ext`, set `key_down`←1, pulse `press_stb`, increment `press_cnt` (modulo 2^CNT_W).
    - else (typematic repeat of the held key): no change.
    - clear `ext_q`.
- `F0` received while `brk`=1: set `err`, keep `brk`=1.
- `E0` received while `ext_q`=1: no effect.
- `key_ascii` is produced by the lookup sub-module from `key_code` and `shift`:
  - covers letters, digits, space, enter.
  - lowercase/uppercase and digit/symbol selected by `shift`.
  - registered, so it updates one cycle after `key_code` or `shift` changes.
- `err` additionally ORs in `kb_overflow` on every cycle.

## Timing
- One byte consumed per 3 cycles minimum (IDLE→POP→PROC).
- The next byte is sampled in IDLE no earlier than the cycle after PROC.
- Rationale: the receiver updates `kb_ready` on the same edge that it advances its read pointer, so `kb_ready` is valid again by that cycle.
- `nextdata_n` is never low for two consecutive cycles and is never low when the FSM was not in POP.
- `press_stb`, `key_code`, `key_down` and `press_cnt` update on the edge leaving PROC. `key_ascii` updates one edge later.
- `clrn` asserted mid-sequence, including during POP: all outputs return to reset values asynchronously, `nextdata_n` goes to 1, and the FSM goes to IDLE. The receiver is reset by the same `clrn`.
- `press_cnt` wrap: 0xFF → 0x00 on the next press, and `press_stb` still pulses.

## Structure
- Package `ps2_pkg`:
  - constants `SC_BREAK`=8'hF0, `SC_EXT`=8'hE0, `SC_LSHIFT`=8'h12, `SC_RSHIFT`=8'h59.
  - FSM state enum `{IDLE, POP, PROC}`.
- Sub-module `ps2_scan2ascii`: combinational scan-code + shift → ASCII table. The registered output stage lives in the parent.

## Test plan
- FIFO holds 1C, F0, 1C → `key_code`=1C, `key_ascii`=0x61 ('a'), one `press_stb`, `press_cnt`=1, then `key_down`=0 after F0 1C. Exactly three single-cycle `nextdata_n` pulses.
- Sequence 12, 1C, F0, 1C, F0, 12 → `shift`=1 while 1C is held and `key_ascii`=0x41 ('A'). Final `shift`=0, `press_cnt`=1.
- Sequence 1C, 1C, 1C, F0, 1C (typematic) → a single `press_stb`, `press_cnt`=1.
- Sequence E0, 75, F0, 75 (plain break of an extended key) → `key_ext`=1, `key_ascii`=0x00, `key_down` stays 1. A following E0 F0 75 clears it.
- 256 press/release pairs of 16 → `press_cnt` wraps to 0x00, and `press_stb` is counted 256 times.
- `kb_overflow`=1 for one cycle → `err`=1 and stays 1. Then `clrn` pulsed during POP → all outputs at reset values on the next cycle and `nextdata_n`=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Scan-code constants, FSM state type and small helpers shared by the PS/2 key controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PROC = 2'd2
  } state_t;

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Receiver-FIFO handshake bundle: head byte, non-empty flag, overflow flag and active-low pop.
// Latency: n/a (wires only).
// Backpressure: the consumer pops only while kb_ready=1; the receiver holds kb_data until popped.
interface ps2_key_ctrl_if;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       nextdata_n;

  // master: the PS/2 receiver FIFO
  modport master (
    output kb_data,
    output kb_ready,
    output kb_overflow,
    input  nextdata_n
  );

  // slave: the scan-code sequencer draining the FIFO
  modport slave (
    input  kb_data,
    input  kb_ready,
    input  kb_overflow,
    output nextdata_n
  );
endinterface

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scan code + shift to ASCII table (letters, digits, space, enter).
// Latency: 0 cycles; the registered stage lives in the parent.
// Backpressure: none.
// Ports: code (scan code), shift (either shift held), ascii (0x00 when unmapped).
module ps2_scan2ascii (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = shift ? "A" : "a";
      8'h32: ascii = shift ? "B" : "b";
      8'h21: ascii = shift ? "C" : "c";
      8'h23: ascii = shift ? "D" : "d";
      8'h24: ascii = shift ? "E" : "e";
      8'h2B: ascii = shift ? "F" : "f";
      8'h34: ascii = shift ? "G" : "g";
      8'h33: ascii = shift ? "H" : "h";
      8'h43: ascii = shift ? "I" : "i";
      8'h3B: ascii = shift ? "J" : "j";
      8'h42: ascii = shift ? "K" : "k";
      8'h4B: ascii = shift ? "L" : "l";
      8'h3A: ascii = shift ? "M" : "m";
      8'h31: ascii = shift ? "N" : "n";
      8'h44: ascii = shift ? "O" : "o";
      8'h4D: ascii = shift ? "P" : "p";
      8'h15: ascii = shift ? "Q" : "q";
      8'h2D: ascii = shift ? "R" : "r";
      8'h1B: ascii = shift ? "S" : "s";
      8'h2C: ascii = shift ? "T" : "t";
      8'h3C: ascii = shift ? "U" : "u";
      8'h2A: ascii = shift ? "V" : "v";
      8'h1D: ascii = shift ? "W" : "w";
      8'h22: ascii = shift ? "X" : "x";
      8'h35: ascii = shift ? "Y" : "y";
      8'h1A: ascii = shift ? "Z" : "z";
      8'h45: ascii = shift ? ")" : "0";
      8'h16: ascii = shift ? "!" : "1";
      8'h1E: ascii = shift ? "@" : "2";
      8'h26: ascii = shift ? "#" : "3";
      8'h25: ascii = shift ? "$" : "4";
      8'h2E: ascii = shift ? "%" : "5";
      8'h36: ascii = shift ? "^" : "6";
      8'h3D: ascii = shift ? "&" : "7";
      8'h3E: ascii = shift ? "*" : "8";
      8'h46: ascii = shift ? "(" : "9";
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Scan-code sequencer: drains the PS/2 receiver FIFO, decodes make/break/E0, tracks held key, shift, ASCII and press count.
// Latency: 3 cycles per byte (IDLE->POP->PROC); key state updates leaving PROC, key_ascii one edge later.
// Backpressure: pops only when kb_ready=1, one nextdata_n low cycle per byte; never pops twice back-to-back.
// Ports: clk, clrn (async active-high reset), kb (receiver handshake, slave side),
//        key_code/key_ext/key_ascii/key_down/shift, press_stb/press_cnt, err (sticky).
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  ps2_key_ctrl_if.slave    kb,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic             shift,
  output logic             press_stb,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err
);

  state_t     state;
  logic [7:0] byte_q;
  logic       brk;
  logic       ext_q;
  logic       nd_q;
  logic [7:0] ascii_c;
  logic       proto_err;

  assign kb.nextdata_n = nd_q;

  // A second F0 before the key code arrives is the only protocol error recognised.
  assign proto_err = (state == PROC) && (byte_q == SC_BREAK) && brk;

  ps2_scan2ascii u_scan2ascii (
    .code  (key_code),
    .shift (shift),
    .ascii (ascii_c)
  );

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state     <= IDLE;
      byte_q    <= 8'h00;
      brk       <= 1'b0;
      ext_q     <= 1'b0;
      nd_q      <= 1'b1;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_ascii <= 8'h00;
      key_down  <= 1'b0;
      shift     <= 1'b0;
      press_stb <= 1'b0;
      press_cnt <= '0;
      err       <= 1'b0;
    end else begin
      press_stb <= 1'b0;
      nd_q      <= 1'b1;
      err       <= err | kb.kb_overflow | proto_err;
      // Extended keys have no printable mapping.
      key_ascii <= key_ext ? 8'h00 : ascii_c;

      case (state)
        IDLE: begin
          if (kb.kb_ready) begin
            byte_q <= kb.kb_data;
            nd_q   <= 1'b0;   // low exactly while in POP
            state  <= POP;
          end
        end

        POP: begin
          state <= PROC;
        end

        PROC: begin
          state <= IDLE;
          if (byte_q == SC_EXT) begin
            ext_q <= 1'b1;
          end else if (byte_q == SC_BREAK) begin
            brk <= 1'b1;
          end else if (brk) begin
            // Release. Only the matching key clears key_down; key_code is kept for display.
            if (is_shift_code(byte_q)) begin
              shift <= 1'b0;
            end else if ((byte_q == key_code) && (ext_q == key_ext)) begin
              key_down <= 1'b0;
            end
            brk   <= 1'b0;
            ext_q <= 1'b0;
          end else begin
            // Make. An E0-prefixed shift code is not a real shift and counts as a key.
            if (is_shift_code(byte_q) && !ext_q) begin
              shift <= 1'b1;
            end else if (!key_down || (byte_q != key_code) || (ext_q != key_ext)) begin
              key_code  <= byte_q;
              key_ext   <= ext_q;
              key_down  <= 1'b1;
              press_stb <= 1'b1;
              press_cnt <= press_cnt + 1'b1;
            end
            ext_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
module tb_ps2_key_ctrl;

  logic       clk;
  logic       clrn;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_down;
  logic       shift;
  logic       press_stb;
  logic [7:0] press_cnt;
  logic       err;

  // receiver FIFO model
  logic [7:0] mem [256];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  logic       kb_overflow;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int nd_cnt = 0;
  logic prev_nd = 1'b1;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic [7:0] cnt;
    logic [7:0] ascii;
  } exp_t;

  exp_t exp_q[$];
  logic       asc_pend = 1'b0;
  logic [7:0] pend_ascii = 8'h00;

  ps2_key_ctrl_if kb_if ();

  assign kb_if.kb_data     = mem[rd_ptr];
  assign kb_if.kb_ready    = (rd_ptr != wr_ptr);
  assign kb_if.kb_overflow = kb_overflow;

  ps2_key_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .kb        (kb_if.slave),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_ascii (key_ascii),
    .key_down  (key_down),
    .shift     (shift),
    .press_stb (press_stb),
    .press_cnt (press_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The receiver advances its read pointer on the edge where it sees the pop.
  always @(posedge clk or posedge clrn) begin
    if (clrn) rd_ptr <= 8'h00;
    else if (!kb_if.nextdata_n) rd_ptr <= rd_ptr + 8'h01;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each press pulse against the scoreboard, and the ASCII one cycle later.
  always @(negedge clk) begin
    if (clrn) begin
      asc_pend = 1'b0;
      prev_nd  = 1'b1;
    end else begin
      if (asc_pend) begin
        chk("press_ascii", {24'h0, key_ascii}, {24'h0, pend_ascii});
        asc_pend = 1'b0;
      end
      if (press_stb) begin
        stb_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_press: got code 0x%0h cnt %0d expected no press", key_code, press_cnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("press_code", {24'h0, key_code}, {24'h0, e.code});
          chk("press_ext", {31'h0, key_ext}, {31'h0, e.ext});
          chk("press_cnt", {24'h0, press_cnt}, {24'h0, e.cnt});
          chk("press_down", {31'h0, key_down}, 32'h1);
          pend_ascii = e.ascii;
          asc_pend   = 1'b1;
        end
      end
      if (!kb_if.nextdata_n) begin
        nd_cnt++;
        if (!prev_nd) chk("nextdata_n_double_low", 32'h0, 32'h1);
      end
      prev_nd = kb_if.nextdata_n;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'h01;
  endtask

  task automatic expect_press(input logic [7:0] code, input logic ext,
                              input logic [7:0] cnt, input logic [7:0] ascii);
    exp_t e;
    e.code = code; e.ext = ext; e.cnt = cnt; e.ascii = ascii;
    exp_q.push_back(e);
  endtask

  // Wait until all pushed bytes are popped, then PROC and the ASCII stage settle.
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((rd_ptr != wr_ptr) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk({name, "_drain_timeout"}, 32'h0, 32'h1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_nextdata_n"}, {31'h0, kb_if.nextdata_n}, 32'h1);
    chk({name, "_key_code"},   {24'h0, key_code}, 32'h0);
    chk({name, "_key_ext"},    {31'h0, key_ext}, 32'h0);
    chk({name, "_key_ascii"},  {24'h0, key_ascii}, 32'h0);
    chk({name, "_key_down"},   {31'h0, key_down}, 32'h0);
    chk({name, "_shift"},      {31'h0, shift}, 32'h0);
    chk({name, "_press_stb"},  {31'h0, press_stb}, 32'h0);
    chk({name, "_press_cnt"},  {24'h0, press_cnt}, 32'h0);
    chk({name, "_err"},        {31'h0, err}, 32'h0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    clrn = 1'b1;
    wr_ptr = 8'h00;
    kb_overflow = 1'b0;
    @(negedge clk);
    check_reset_outputs(name);
    clrn = 1'b0;
    nd_cnt = 0;
    stb_cnt = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clrn = 1'b1;
    kb_overflow = 1'b0;
    wr_ptr = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    clrn = 1'b0;

    // 1: press and release 'a'
    do_reset("rst1");
    expect_press(8'h1C, 1'b0, 8'd1, "a");
    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    drain("t1");
    chk("t1_key_code", {24'h0, key_code}, 32'h1C);
    chk("t1_key_down", {31'h0, key_down}, 32'h0);
    chk("t1_press_cnt", {24'h0, press_cnt}, 32'd1);
    chk("t1_nd_pulses", nd_cnt, 32'd3);
    chk("t1_stb", stb_cnt, 32'd1);

    // 2: shifted 'A'
    do_reset("rst2");
    expect_press(8'h1C, 1'b0, 8'd1, "A");
    push_byte(8'h12); push_byte(8'h1C); push_byte(8'hF0);
    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h12);
    drain("t2");
    chk("t2_shift", {31'h0, shift}, 32'h0);
    chk("t2_press_cnt", {24'h0, press_cnt}, 32'd1);
    chk("t2_key_down", {31'h0, key_down}, 32'h0);

    // 3: typematic repeat counts once
    do_reset("rst3");
    expect_press(8'h1C, 1'b0, 8'd1, "a");
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
    push_byte(8'hF0); push_byte(8'h1C);
    drain("t3");
    chk("t3_stb", stb_cnt, 32'd1);
    chk("t3_press_cnt", {24'h0, press_cnt}, 32'd1);

    // 4: extended key, non-extended break does not release it
    do_reset("rst4");
    expect_press(8'h75, 1'b1, 8'd1, 8'h00);
    push_byte(8'hE0); push_byte(8'h75); push_byte(8'hF0); push_byte(8'h75);
    drain("t4a");
    chk("t4_key_ext", {31'h0, key_ext}, 32'h1);
    chk("t4_key_ascii", {24'h0, key_ascii}, 32'h0);
    chk("t4_key_down_held", {31'h0, key_down}, 32'h1);
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    drain("t4b");
    chk("t4_key_down_rel", {31'h0, key_down}, 32'h0);
    chk("t4_key_code_kept", {24'h0, key_code}, 32'h75);

    // 5: 256 press/release pairs wrap the counter
    do_reset("rst5");
    for (int i = 0; i < 256; i++) begin
      expect_press(8'h16, 1'b0, 8'((i + 1) % 256), "1");
      push_byte(8'h16); push_byte(8'hF0); push_byte(8'h16);
      drain("t5");
    end
    chk("t5_stb", stb_cnt, 32'd256);
    chk("t5_press_cnt", {24'h0, press_cnt}, 32'h0);

    // 6: overflow is sticky; reset during POP restores everything
    do_reset("rst6");
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_err_sticky", {31'h0, err}, 32'h1);
    push_byte(8'h1C);
    n = 0;
    while (kb_if.nextdata_n && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_pop", {31'h0, kb_if.nextdata_n}, 32'h0);
    clrn = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    wr_ptr = 8'h00;
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("t6_after");

    // 7: double F0 is a protocol error
    do_reset("rst7");
    push_byte(8'hF0); push_byte(8'hF0); push_byte(8'h1C);
    drain("t7");
    chk("t7_err", {31'h0, err}, 32'h1);
    chk("t7_key_down", {31'h0, key_down}, 32'h0);
    chk("t7_stb", stb_cnt, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
